branch_target_table: RTL and testbench

Writable, parametrised branch-target table for the basic processor's fetch stage, replacing the fixed combinational target LUT. Software or the loader programs entries through a write port. Fetch issues a lookup and gets a registered target, a hit flag and a valid strobe one cycle later. A built-in sequencer clears every entry after reset or on request, and the table reports occupancy.

---
 rtl/branch_target_table_if.sv | 30 +++
 rtl/branch_target_table.sv | 152 +++++++++++++++
 tb/tb_branch_target_table.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_table_if.sv
// Bus interface of the branch-target table.
// Carries the lookup port (RdEn/RdAddr -> RdTarget/RdHit/RdValid), the
// write port (WrEn/WrAddr/WrData), the clear request and status (Busy/Count).
// master: fetch/loader side that issues requests; slave: the table itself.
interface branch_target_table_if #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned TARGET_W = 10
);
   logic                Clear;
   logic                RdEn;
   logic [ADDR_W-1:0]   RdAddr;
   logic [TARGET_W-1:0] RdTarget;
   logic                RdHit;
   logic                RdValid;
   logic                WrEn;
   logic [ADDR_W-1:0]   WrAddr;
   logic [TARGET_W-1:0] WrData;
   logic                Busy;
   logic [ADDR_W:0]     Count;

   modport master (
      output Clear, RdEn, RdAddr, WrEn, WrAddr, WrData,
      input  RdTarget, RdHit, RdValid, Busy, Count
   );

   modport slave (
      input  Clear, RdEn, RdAddr, WrEn, WrAddr, WrData,
      output RdTarget, RdHit, RdValid, Busy, Count
   );
endinterface

// File: rtl/branch_target_table.sv
// Writable branch-target table for the fetch stage.
// Ports:
//   Clk    - clock, all state updates on the rising edge
//   Reset  - synchronous active-high reset; restarts the clear sequence
//   bus    - slave modport: lookup port with registered target/hit/valid,
//            write port, clear request, Busy and occupancy Count
// After reset or an accepted Clear, a sequencer walks every entry, loading
// DEFAULT_TARGET and dropping its valid bit; requests are ignored meanwhile.
module branch_target_table #(
   parameter int unsigned ADDR_W         = 5,
   parameter int unsigned TARGET_W       = 10,
   parameter int unsigned DEFAULT_TARGET = 0
) (
   input logic                  Clk,
   input logic                  Reset,
   branch_target_table_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [TARGET_W-1:0] rd_target_q, rd_target_d;
   logic                rd_hit_q, rd_hit_d;
   logic                rd_valid_q, rd_valid_d;

   logic [TARGET_W-1:0] target_q [DEPTH];
   logic [TARGET_W-1:0] target_d [DEPTH];
   logic [DEPTH-1:0]    valid_q, valid_d;

   logic rd_fire_c;
   logic wr_fire_c;
   logic clr_fire_c;
   logic bypass_c;

   // Request qualification: nothing is accepted while the sequencer runs,
   // and a write that coincides with an accepted Clear is dropped.
   always_comb begin
      rd_fire_c  = 1'b0;
      wr_fire_c  = 1'b0;
      clr_fire_c = 1'b0;
      bypass_c   = 1'b0;
      if (state_q == READY) begin
         rd_fire_c  = bus.RdEn;
         clr_fire_c = bus.Clear;
         wr_fire_c  = bus.WrEn & ~bus.Clear;
         bypass_c   = wr_fire_c & bus.RdEn & (bus.WrAddr == bus.RdAddr);
      end
   end

   // Next-state logic for the clear sequencer.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         INIT: begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = READY;
            end
         end
         READY: begin
            if (bus.Clear) begin
               state_d = INIT;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = INIT;
            ptr_d   = '0;
         end
      endcase
   end

   // Array update: sequencer clear has priority; writes only land in READY.
   always_comb begin
      target_d = target_q;
      valid_d  = valid_q;
      if (state_q == INIT) begin
         target_d[ptr_q] = TARGET_W'(DEFAULT_TARGET);
         valid_d[ptr_q]  = 1'b0;
      end else if (wr_fire_c) begin
         target_d[bus.WrAddr] = bus.WrData;
         valid_d[bus.WrAddr]  = 1'b1;
      end
   end

   // Occupancy: only a write to a currently invalid entry adds one.
   always_comb begin
      count_d = count_q;
      if ((state_q == INIT) || clr_fire_c) begin
         count_d = '0;
      end else if (wr_fire_c && !valid_q[bus.WrAddr] &&
                   (count_q != CNT_W'(DEPTH))) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Lookup result; holds target/hit when no lookup is accepted.
   always_comb begin
      rd_target_d = rd_target_q;
      rd_hit_d    = rd_hit_q;
      rd_valid_d  = rd_fire_c;
      if (rd_fire_c) begin
         if (bypass_c) begin
            rd_target_d = bus.WrData;
            rd_hit_d    = 1'b1;
         end else begin
            rd_target_d = target_q[bus.RdAddr];
            rd_hit_d    = valid_q[bus.RdAddr];
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= INIT;
         ptr_q       <= '0;
         count_q     <= '0;
         rd_target_q <= '0;
         rd_hit_q    <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         count_q     <= count_d;
         rd_target_q <= rd_target_d;
         rd_hit_q    <= rd_hit_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   // Storage is not reset; the sequencer initialises it after every reset.
   always_ff @(posedge Clk) begin
      target_q <= target_d;
      valid_q  <= valid_d;
   end

   assign bus.RdTarget = rd_target_q;
   assign bus.RdHit    = rd_hit_q;
   assign bus.RdValid  = rd_valid_q;
   assign bus.Count    = count_q;
   assign bus.Busy     = (state_q == INIT);

endmodule

// File: tb/tb_branch_target_table.sv
module tb_branch_target_table;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned TARGET_W = 10;
   localparam int unsigned DEPTH    = 32;
   localparam int unsigned DEF_T    = 0;

   logic clk;
   logic reset;

   branch_target_table_if #(.ADDR_W(ADDR_W), .TARGET_W(TARGET_W)) bus ();

   branch_target_table #(
      .ADDR_W(ADDR_W), .TARGET_W(TARGET_W), .DEFAULT_TARGET(DEF_T)
   ) dut (
      .Clk(clk), .Reset(reset), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: table contents, valid flags, remaining clear cycles
   // and the expected registered lookup outputs.
   int m_tgt [DEPTH];
   bit m_val [DEPTH];
   int busy_left;
   int e_target;
   bit e_hit;
   bit e_valid;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < int'(DEPTH); i++) c += int'(m_val[i]);
      return c;
   endfunction

   function automatic void m_wipe();
      for (int i = 0; i < int'(DEPTH); i++) begin
         m_tgt[i] = DEF_T;
         m_val[i] = 1'b0;
      end
   endfunction

   // Drive one cycle of inputs, advance one edge, update the model.
   task automatic tick(input bit rst, input bit clr, input bit re, input int ra,
                       input bit we, input int wa, input int wd);
      reset      = rst;
      bus.Clear  = clr;
      bus.RdEn   = re;
      bus.RdAddr = ADDR_W'(ra);
      bus.WrEn   = we;
      bus.WrAddr = ADDR_W'(wa);
      bus.WrData = TARGET_W'(wd);
      @(posedge clk);
      #1;
      if (rst) begin
         m_wipe();
         busy_left = DEPTH;
         e_target  = 0;
         e_hit     = 0;
         e_valid   = 0;
      end else if (busy_left > 0) begin
         busy_left--;
         e_valid = 0;
      end else begin
         if (re) begin
            if (we && !clr && (wa == ra)) begin
               e_target = wd;
               e_hit    = 1;
            end else begin
               e_target = m_tgt[ra];
               e_hit    = m_val[ra];
            end
            e_valid = 1;
         end else begin
            e_valid = 0;
         end
         if (we && !clr) begin
            m_tgt[wa] = wd;
            m_val[wa] = 1;
         end
         if (clr) begin
            m_wipe();
            busy_left = DEPTH;
         end
      end
   endtask

   task automatic idle();
      tick(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      int n;
      for (int i = 0; i < 3; i++) tick(1, 0, 1, $urandom_range(31), 1, $urandom_range(31), $urandom_range(1023));
      checks++; if (bus.Busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%0d exp=1", bus.Busy); end
      checks++; if (bus.Count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.Count); end
      checks++; if (bus.RdValid !== 1'b0 || bus.RdHit !== 1'b0 || bus.RdTarget !== 10'd0) begin
         failures++; $display("FAIL reset_rd got=%0d/%0d/%0d exp=0/0/0", bus.RdValid, bus.RdHit, bus.RdTarget);
      end
      n = 0;
      while (bus.Busy === 1'b1 && n < 40) begin
         tick(0, $urandom_range(1), 1, $urandom_range(31), 1, $urandom_range(31), $urandom_range(1023));
         n++;
         checks++; if (bus.RdValid !== 1'b0 || bus.Count !== 6'd0) begin
            failures++; $display("FAIL init_quiet cyc=%0d got valid=%0d count=%0d exp=0/0", n, bus.RdValid, bus.Count);
         end
      end
      checks++; if (n != 32) begin failures++; $display("FAIL init_len got=%0d exp=32", n); end
   endtask

   task automatic test_miss();
      tick(0, 0, 1, 6, 0, 0, 0);
      checks++; if (bus.RdValid !== 1'b1 || bus.RdHit !== 1'b0 || bus.RdTarget !== 10'd0) begin
         failures++; $display("FAIL miss got=%0d/%0d/%0d exp=1/0/0", bus.RdValid, bus.RdHit, bus.RdTarget);
      end
      idle();
      checks++; if (bus.RdValid !== 1'b0 || bus.RdTarget !== 10'd0) begin
         failures++; $display("FAIL miss_idle got=%0d/%0d exp=0/0", bus.RdValid, bus.RdTarget);
      end
   endtask

   task automatic test_write_read();
      tick(0, 0, 0, 0, 1, 1, 179);
      tick(0, 0, 0, 0, 1, 2, 314);
      tick(0, 0, 1, 1, 0, 0, 0);
      checks++; if (bus.RdTarget !== 10'd179 || bus.RdHit !== 1'b1 || bus.RdValid !== 1'b1) begin
         failures++; $display("FAIL rd1 got=%0d/%0d exp=179/1", bus.RdTarget, bus.RdHit);
      end
      tick(0, 0, 1, 2, 0, 0, 0);
      checks++; if (bus.RdTarget !== 10'd314 || bus.RdHit !== 1'b1) begin
         failures++; $display("FAIL rd2 got=%0d/%0d exp=314/1", bus.RdTarget, bus.RdHit);
      end
      checks++; if (bus.Count !== 6'd2) begin failures++; $display("FAIL count2 got=%0d exp=2", bus.Count); end
      tick(0, 0, 0, 0, 1, 1, 403);
      checks++; if (bus.Count !== 6'd2) begin failures++; $display("FAIL rewrite_count got=%0d exp=2", bus.Count); end
      // Hold after a served read: RdEn low keeps target/hit.
      tick(0, 0, 1, 1, 0, 0, 0);
      idle();
      checks++; if (bus.RdTarget !== 10'd403 || bus.RdHit !== 1'b1 || bus.RdValid !== 1'b0) begin
         failures++; $display("FAIL rewrite_rd got=%0d/%0d/%0d exp=403/1/0", bus.RdTarget, bus.RdHit, bus.RdValid);
      end
   endtask

   task automatic test_bypass();
      tick(0, 0, 1, 7, 1, 7, 408);
      checks++; if (bus.RdTarget !== 10'd408 || bus.RdHit !== 1'b1) begin
         failures++; $display("FAIL bypass got=%0d/%0d exp=408/1", bus.RdTarget, bus.RdHit);
      end
      tick(0, 0, 1, 9, 1, 8, 555);
      checks++; if (bus.RdHit !== 1'b0 || bus.RdTarget !== 10'd0) begin
         failures++; $display("FAIL diff_addr got=%0d/%0d exp=0/0", bus.RdTarget, bus.RdHit);
      end
      tick(0, 0, 1, 8, 1, 8, 600);
      checks++; if (bus.RdTarget !== 10'd600 || bus.Count !== 6'd4) begin
         failures++; $display("FAIL bypass_valid got=%0d count=%0d exp=600/4", bus.RdTarget, bus.Count);
      end
   endtask

   task automatic test_fill_clear();
      int n;
      for (int i = 0; i < 32; i++) tick(0, 0, 0, 0, 1, i, i + 400);
      checks++; if (bus.Count !== 6'd32) begin failures++; $display("FAIL fill_count got=%0d exp=32", bus.Count); end
      for (int i = 0; i < 32; i++) tick(0, 0, 0, 0, 1, i, i + 100);
      checks++; if (bus.Count !== 6'd32) begin failures++; $display("FAIL refill_count got=%0d exp=32", bus.Count); end
      tick(0, 1, 1, 31, 1, 3, 9);
      checks++; if (bus.Busy !== 1'b1 || bus.Count !== 6'd0 || bus.RdTarget !== 10'd131 || bus.RdHit !== 1'b1) begin
         failures++; $display("FAIL clear_start got busy=%0d count=%0d tgt=%0d hit=%0d exp=1/0/131/1",
                              bus.Busy, bus.Count, bus.RdTarget, bus.RdHit);
      end
      n = 0;
      while (bus.Busy === 1'b1 && n < 40) begin
         tick(0, 0, 0, 0, 1, 31, 77);
         n++;
      end
      checks++; if (n != 32) begin failures++; $display("FAIL clear_len got=%0d exp=32", n); end
      tick(0, 0, 1, 31, 0, 0, 0);
      checks++; if (bus.RdHit !== 1'b0 || bus.RdTarget !== 10'd0 || bus.Count !== 6'd0) begin
         failures++; $display("FAIL after_clear got=%0d/%0d count=%0d exp=0/0/0", bus.RdTarget, bus.RdHit, bus.Count);
      end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      tick(0, 0, 0, 0, 1, 5, 77);
      tick(0, 1, 1, 5, 0, 0, 0);
      checks++; if (bus.RdTarget !== 10'd77 || bus.RdHit !== 1'b1 || bus.RdValid !== 1'b1) begin
         failures++; $display("FAIL clear_read got=%0d/%0d/%0d exp=77/1/1", bus.RdTarget, bus.RdHit, bus.RdValid);
      end
      for (int i = 0; i < 10; i++) idle();
      tick(1, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.Busy !== 1'b1 || bus.Count !== 6'd0 || bus.RdTarget !== 10'd0 ||
                    bus.RdHit !== 1'b0 || bus.RdValid !== 1'b0) begin
         failures++; $display("FAIL midreset got busy=%0d count=%0d tgt=%0d hit=%0d vld=%0d exp=1/0/0/0/0",
                              bus.Busy, bus.Count, bus.RdTarget, bus.RdHit, bus.RdValid);
      end
      n = 0;
      while (bus.Busy === 1'b1 && n < 40) begin
         idle();
         n++;
      end
      checks++; if (n != 32) begin failures++; $display("FAIL midreset_len got=%0d exp=32", n); end
   endtask

   task automatic test_random();
      bit clr, re, we;
      int ra, wa;
      for (int c = 0; c < 600; c++) begin
         clr = ($urandom_range(59) == 0);
         re  = $urandom_range(1);
         we  = ($urandom_range(3) != 0);
         ra  = $urandom_range(31);
         wa  = ($urandom_range(3) == 0) ? ra : $urandom_range(31);
         tick(($urandom_range(299) == 0), clr, re, ra, we, wa, $urandom_range(1023));
         checks++;
         if (bus.RdValid !== e_valid || bus.RdHit !== e_hit || bus.RdTarget !== TARGET_W'(e_target) ||
             bus.Busy !== (busy_left > 0) || bus.Count !== 6'(m_count())) begin
            failures++;
            $display("FAIL random cyc=%0d got vld=%0d hit=%0d tgt=%0d busy=%0d cnt=%0d exp %0d/%0d/%0d/%0d/%0d",
                     c, bus.RdValid, bus.RdHit, bus.RdTarget, bus.Busy, bus.Count,
                     e_valid, e_hit, e_target, (busy_left > 0), m_count());
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.Clear = 0; bus.RdEn = 0; bus.RdAddr = '0;
      bus.WrEn = 0; bus.WrAddr = '0; bus.WrData = '0;
      m_wipe();
      busy_left = DEPTH; e_target = 0; e_hit = 0; e_valid = 0;
      test_reset();
      test_miss();
      test_write_read();
      test_bypass();
      test_fill_clear();
      test_reset_mid_clear();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
